// File: rtl/wwd_checker.sv
// Run monitor grading a CPU's WWD output against a loaded checkpoint table; 1-cycle registered compare, no backpressure.
// Optional WWD_CHECKER_STOP_ON_FAIL_EN: first failing checkpoint ends the run (done_reason 3).
module wwd_checker #(
  parameter int WORD_SIZE  = 16,
  parameter int NUM_TEST   = 56,
  parameter int IDX_W      = 6,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 10000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_en,
  input  logic [IDX_W-1:0]     load_idx,
  input  logic [WORD_SIZE-1:0] load_inst,
  input  logic [WORD_SIZE-1:0] load_ans,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] num_inst,
  input  logic [WORD_SIZE-1:0] output_port,
  input  logic                 is_halted,
  output logic [1:0]           state,
  output logic [IDX_W:0]       ptr,
  output logic [IDX_W:0]       pass_count,
  output logic [IDX_W:0]       fail_count,
  output logic [IDX_W:0]       miss_count,
  output logic [IDX_W-1:0]     first_fail_idx,
  output logic [WORD_SIZE-1:0] first_fail_val,
  output logic [CNT_W-1:0]     cycle_count,
  output logic                 done,
  output logic                 all_pass,
  output logic [1:0]           done_reason
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W:0]   NUM_P    = (IDX_W+1)'(NUM_TEST);
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);

  state_t cur_state, nxt_state;
  logic [1:0] reason_nxt;

  logic [WORD_SIZE-1:0] tbl_inst [NUM_TEST];
  logic [WORD_SIZE-1:0] tbl_ans  [NUM_TEST];

  logic [WORD_SIZE-1:0] e_inst, e_ans;
  logic chk_en, is_hit, is_pass, is_fail, is_miss, timeout, stop_fail;

  // Table has no reset so a loaded program survives reset_n between runs.
  always_ff @(posedge clk) begin
    if (cur_state == S_IDLE && load_en) begin
      for (int i = 0; i < NUM_TEST; i++) begin
        if (load_idx == IDX_W'(i)) begin
          tbl_inst[i] <= load_inst;
          tbl_ans[i]  <= load_ans;
        end
      end
    end
  end

  always_comb begin
    e_inst = '0;
    e_ans  = '0;
    for (int i = 0; i < NUM_TEST; i++) begin
      if (ptr == (IDX_W+1)'(i)) begin
        e_inst = tbl_inst[i];
        e_ans  = tbl_ans[i];
      end
    end
  end

  assign chk_en  = (cur_state == S_RUN) && (ptr < NUM_P);
  assign is_hit  = chk_en && (num_inst == e_inst);
  assign is_pass = is_hit && (output_port == e_ans);
  assign is_fail = is_hit && (output_port != e_ans);
  assign is_miss = chk_en && (num_inst > e_inst);
  assign timeout = (cycle_count == CYC_LAST);

`ifdef WWD_CHECKER_STOP_ON_FAIL_EN
  assign stop_fail = is_fail;
`else
  assign stop_fail = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_state   <= S_IDLE;
      done_reason <= 2'd0;
    end else begin
      cur_state   <= nxt_state;
      done_reason <= reason_nxt;
    end
  end

  // Termination priority: fail stop, then halt, then timeout.
  always_comb begin
    nxt_state  = cur_state;
    reason_nxt = done_reason;
    case (cur_state)
      S_IDLE: begin
        if (start) nxt_state = S_RUN;
      end
      S_RUN: begin
        if (stop_fail) begin
          nxt_state  = S_DONE;
          reason_nxt = 2'd3;
        end else if (is_halted) begin
          nxt_state  = S_DONE;
          reason_nxt = 2'd1;
        end else if (timeout) begin
          nxt_state  = S_DONE;
          reason_nxt = 2'd2;
        end
      end
      S_DONE: begin
        nxt_state = S_DONE;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr            <= '0;
      pass_count     <= '0;
      fail_count     <= '0;
      miss_count     <= '0;
      first_fail_idx <= '0;
      first_fail_val <= '0;
      cycle_count    <= '0;
    end else if (cur_state == S_RUN) begin
      if (!timeout) cycle_count <= cycle_count + 1'b1;
      if (is_pass) begin
        pass_count <= pass_count + 1'b1;
        ptr        <= ptr + 1'b1;
      end else if (is_fail) begin
        fail_count <= fail_count + 1'b1;
        ptr        <= ptr + 1'b1;
        if (fail_count == '0) begin
          first_fail_idx <= ptr[IDX_W-1:0];
          first_fail_val <= output_port;
        end
      end else if (is_miss) begin
        miss_count <= miss_count + 1'b1;
        ptr        <= ptr + 1'b1;
      end
    end
  end

  assign state    = cur_state;
  assign done     = (cur_state == S_DONE);
  assign all_pass = done && (pass_count == NUM_P);

endmodule

// File: tb/tb_wwd_checker.sv
// Directed bench: dut_a has a 2-entry table, dut_b a 3-entry table; both share inputs and time out after 20 RUN cycles.
module tb_wwd_checker;

`ifdef WWD_CHECKER_STOP_ON_FAIL_EN
  localparam int STOPF = 1;
`else
  localparam int STOPF = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, load_en, start, is_halted;
  logic [1:0]  load_idx;
  logic [15:0] load_inst, load_ans, num_inst, output_port;

  logic [1:0]  a_state, a_reason, b_state, b_reason;
  logic [2:0]  a_ptr, a_pass, a_fail, a_miss, b_ptr, b_pass, b_fail, b_miss;
  logic [1:0]  a_ffidx, b_ffidx;
  logic [15:0] a_ffval, b_ffval, a_cc, b_cc;
  logic        a_done, a_allp, b_done, b_allp;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  wwd_checker #(.WORD_SIZE(16), .NUM_TEST(2), .IDX_W(2), .CNT_W(16), .MAX_CYCLES(20)) dut_a (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_idx(load_idx),
    .load_inst(load_inst), .load_ans(load_ans), .start(start), .num_inst(num_inst),
    .output_port(output_port), .is_halted(is_halted), .state(a_state), .ptr(a_ptr),
    .pass_count(a_pass), .fail_count(a_fail), .miss_count(a_miss),
    .first_fail_idx(a_ffidx), .first_fail_val(a_ffval), .cycle_count(a_cc),
    .done(a_done), .all_pass(a_allp), .done_reason(a_reason));

  wwd_checker #(.WORD_SIZE(16), .NUM_TEST(3), .IDX_W(2), .CNT_W(16), .MAX_CYCLES(20)) dut_b (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_idx(load_idx),
    .load_inst(load_inst), .load_ans(load_ans), .start(start), .num_inst(num_inst),
    .output_port(output_port), .is_halted(is_halted), .state(b_state), .ptr(b_ptr),
    .pass_count(b_pass), .fail_count(b_fail), .miss_count(b_miss),
    .first_fail_idx(b_ffidx), .first_fail_val(b_ffval), .cycle_count(b_cc),
    .done(b_done), .all_pass(b_allp), .done_reason(b_reason));

  typedef struct {
    int rst_n, ld, idx, linst, lans, st, ni, port, halt;
    int e_state, e_ptr, e_pass, e_fail, e_miss, e_reason, e_ffidx, e_ffval;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    reset_n = 1'b1; load_en = 1'b0; start = 1'b0; is_halted = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic load(input int idx, input int inst, input int ans);
    load_en = 1'b1; load_idx = 2'(idx); load_inst = 16'(inst); load_ans = 16'(ans);
    step();
    load_en = 1'b0;
  endtask

  initial begin
    int fs, fr;
    fs = STOPF ? 2 : 1;
    fr = STOPF ? 3 : 0;
    //              rst ld idx li la st ni pt ht | st ptr ps fl ms rs ffi ffv
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 0, 3, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 1, 1, 5, 2, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{1, 0, 0, 0, 0, 0, 2, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{1, 0, 0, 0, 0, 0, 3, 0, 0,   1, 1, 1, 0, 0, 0, 0, 0};
    vecs[8]  = '{1, 0, 0, 0, 0, 0, 4, 0, 0,   1, 1, 1, 0, 0, 0, 0, 0};
    vecs[9]  = '{1, 0, 0, 0, 0, 0, 5, 2, 0,   1, 2, 2, 0, 0, 0, 0, 0};
    vecs[10] = '{1, 0, 0, 0, 0, 0, 5, 2, 1,   2, 2, 2, 0, 0, 1, 0, 0};
    vecs[11] = '{1, 0, 0, 0, 0, 1, 6, 0, 0,   2, 2, 2, 0, 0, 1, 0, 0};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{1, 0, 0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0};
    vecs[14] = '{1, 0, 0, 0, 0, 0, 3, 0, 0,   1, 1, 1, 0, 0, 0, 0, 0};
    vecs[15] = '{1, 0, 0, 0, 0, 0, 5, 1, 0,   fs, 2, 1, 1, 0, fr, 1, 1};
    vecs[16] = '{1, 0, 0, 0, 0, 0, 6, 0, 1,   2, 2, 1, 1, 0, STOPF ? 3 : 1, 1, 1};

    quiet();
    load_idx = '0; load_inst = '0; load_ans = '0; num_inst = '0; output_port = '0;

    for (int i = 0; i < 17; i++) begin
      reset_n = 1'(vecs[i].rst_n); load_en = 1'(vecs[i].ld); load_idx = 2'(vecs[i].idx);
      load_inst = 16'(vecs[i].linst); load_ans = 16'(vecs[i].lans); start = 1'(vecs[i].st);
      num_inst = 16'(vecs[i].ni); output_port = 16'(vecs[i].port); is_halted = 1'(vecs[i].halt);
      step();
      chk($sformatf("v%0d.state", i), 32'(a_state), vecs[i].e_state);
      chk($sformatf("v%0d.ptr", i), 32'(a_ptr), vecs[i].e_ptr);
      chk($sformatf("v%0d.pass", i), 32'(a_pass), vecs[i].e_pass);
      chk($sformatf("v%0d.fail", i), 32'(a_fail), vecs[i].e_fail);
      chk($sformatf("v%0d.miss", i), 32'(a_miss), vecs[i].e_miss);
      chk($sformatf("v%0d.reason", i), 32'(a_reason), vecs[i].e_reason);
      chk($sformatf("v%0d.ffidx", i), 32'(a_ffidx), vecs[i].e_ffidx);
      chk($sformatf("v%0d.ffval", i), 32'(a_ffval), vecs[i].e_ffval);
      chk($sformatf("v%0d.done", i), 32'(a_done), (vecs[i].e_state == 2) ? 1 : 0);
      chk($sformatf("v%0d.all_pass", i), 32'(a_allp),
          (vecs[i].e_state == 2 && vecs[i].e_pass == 2) ? 1 : 0);
    end

    // Skipped checkpoints drain one per cycle (dut_b, entries 3/5/7).
    do_reset();
    num_inst = 16'd0; output_port = 16'd0;
    load(0, 3, 0); load(1, 5, 0); load(2, 7, 0);
    start = 1'b1; step(); start = 1'b0;
    num_inst = 16'd2; step();
    chk("miss.before_jump", 32'(b_miss), 0);
    num_inst = 16'd9;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("miss.cnt%0d", k), 32'(b_miss), 32'(k));
      chk($sformatf("miss.ptr%0d", k), 32'(b_ptr), 32'(k));
    end
    step();
    chk("miss.exhausted_ptr", 32'(b_ptr), 3);
    chk("miss.exhausted_cnt", 32'(b_miss), 3);
    chk("miss.state_run", 32'(b_state), 1);
    chk("miss.pass_zero", 32'(b_pass), 0);

    // Timeout on dut_a: DONE 20 RUN cycles after entry, cycle_count 19.
    do_reset();
    num_inst = 16'd0;
    start = 1'b1; step(); start = 1'b0;
    chk("to.cc_entry", 32'(a_cc), 0);
    for (int k = 1; k <= 19; k++) step();
    chk("to.state_19", 32'(a_state), 1);
    chk("to.cc_19", 32'(a_cc), 19);
    step();
    chk("to.state_done", 32'(a_state), 2);
    chk("to.reason", 32'(a_reason), 2);
    chk("to.cc_final", 32'(a_cc), 19);
    step();
    chk("to.cc_hold", 32'(a_cc), 19);

    // Reset mid-RUN then regrade with retained table (dut_a entry1 ans is now 0).
    do_reset();
    num_inst = 16'd0; output_port = 16'd0;
    start = 1'b1; step(); start = 1'b0;
    num_inst = 16'd3; step();
    chk("rst.pass_before", 32'(a_pass), 1);
    reset_n = 1'b0; step(); reset_n = 1'b1;
    chk("rst.state", 32'(a_state), 0);
    chk("rst.pass", 32'(a_pass), 0);
    chk("rst.ptr", 32'(a_ptr), 0);
    chk("rst.cc", 32'(a_cc), 0);
    start = 1'b1; num_inst = 16'd0; step(); start = 1'b0;
    num_inst = 16'd3; step();
    num_inst = 16'd5; step();
    chk("rst.regrade_pass", 32'(a_pass), 2);

    // Load with start in the same cycle lands; load during RUN is ignored.
    do_reset();
    num_inst = 16'd0; output_port = 16'd0;
    load_en = 1'b1; load_idx = 2'd1; load_inst = 16'd5; load_ans = 16'd2; start = 1'b1;
    step();
    load_en = 1'b0; start = 1'b0;
    chk("ld.start_state", 32'(a_state), 1);
    load(0, 3, 16'h00FF);
    num_inst = 16'd3; output_port = 16'd0; step();
    chk("ld.run_ignored_pass", 32'(a_pass), 1);
    chk("ld.run_ignored_fail", 32'(a_fail), 0);
    num_inst = 16'd5; output_port = 16'd2; step();
    is_halted = 1'b1; step(); is_halted = 1'b0;
    chk("ld.pass2", 32'(a_pass), 2);
    chk("ld.all_pass", 32'(a_allp), 1);
    chk("ld.reason", 32'(a_reason), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wwd_checker.md
# wwd_checker

Synthesizable, parametrised run monitor for the pipelined CPU with caches. It watches the retired-instruction count, the WWD output port and the halt flag, and checks them against a loadable table of (instruction count, expected value) checkpoints. It reports pass/fail/miss counts, the first failing checkpoint and the termination reason, so an FPGA build or a bare-bones bench can grade a program run without behavioural test code.

## Interface
Parameters:
- WORD_SIZE, 16: width of instruction count, output port and table fields.
- NUM_TEST, 56: number of checkpoint entries.
- IDX_W, 6: entry index width; requires 2^IDX_W ≥ NUM_TEST.
- CNT_W, 16: cycle counter width.
- MAX_CYCLES, 10000: timeout in RUN cycles; must be < 2^CNT_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- load_en  in  1  write one table entry this cycle (IDLE only).
- load_idx  in  IDX_W  entry index to write.
- load_inst  in  WORD_SIZE  checkpoint instruction count.
- load_ans  in  WORD_SIZE  expected output_port value.
- start  in  1  one-cycle pulse, IDLE→RUN.
- num_inst  in  WORD_SIZE  CPU retired-instruction count.
- output_port  in  WORD_SIZE  CPU WWD port.
- is_halted  in  1  CPU halt flag.
- state  out  2  0 IDLE, 1 RUN, 2 DONE.
- ptr  out  IDX_W+1  next entry to check; NUM_TEST means exhausted.
- pass_count, fail_count, miss_count  out  IDX_W+1 each  per-outcome entry counts.
- first_fail_idx  out  IDX_W  index of the first failing entry.
- first_fail_val  out  WORD_SIZE  output_port value seen at that entry.
- cycle_count  out  CNT_W  RUN cycles elapsed.
- done  out  1  state == DONE.
- all_pass  out  1  done && pass_count == NUM_TEST.
- done_reason  out  2  0 none, 1 halted, 2 timeout, 3 fail stop.

## Operation
- Table: NUM_TEST × (inst, ans) registers. It is written only in IDLE when load_en=1; load_en in RUN or DONE is ignored. Reset does not clear the table. Entries must be strictly ascending in inst; they are checked in index order.
- IDLE: counters hold their reset values. start=1 → RUN. If load_en and start arrive together, the write completes and the FSM enters RUN.
- RUN, each cycle with ptr < NUM_TEST, comparing e = table[ptr]:
  - num_inst == e.inst and output_port == e.ans: pass_count+1, ptr+1.
  - num_inst == e.inst and the values differ: fail_count+1, ptr+1. If this is the first fail, latch first_fail_idx and first_fail_val.
  - num_inst > e.inst (checkpoint skipped): miss_count+1, ptr+1. Only one entry advances per cycle, so multiple skipped entries drain over consecutive cycles.
  - num_inst < e.inst: no change.
- ptr == NUM_TEST: no further checks; RUN continues until a termination condition.
- cycle_count increments every RUN cycle and holds in DONE.
- Termination, evaluated after the same-cycle check. Priority: fail stop (3) > halted (1) > timeout (2).
  - is_halted=1 → DONE, reason 1.
  - cycle_count == MAX_CYCLES-1 while in RUN → DONE, reason 2.
- DONE: every output holds until reset. start is ignored.
- Reset (reset_n=0 at a rising edge, in any state, including mid-RUN): state=IDLE, ptr=0, all counts 0, first_fail_idx=0, first_fail_val=0, cycle_count=0, done_reason=0, done=0, all_pass=0.

## Timing
- Single-cycle compare. The inputs sampled at edge k are reflected in the counters, ptr and state after edge k.
- A checkpoint is graded on the first RUN cycle where num_inst reaches it. Later cycles at the same num_inst are checked against the next entry.
- A halt on the same edge as a matching checkpoint: the entry is graded first, then state becomes DONE.
- start→RUN takes 1 cycle. The first compare happens on the edge after RUN is entered.
- All outputs are registered except done and all_pass, which are combinational from registered state.

## Configuration
- WWD_CHECKER_STOP_ON_FAIL_EN defined: the first fail forces DONE with done_reason=3 on the same edge. This overrides halt and timeout on that edge.
- Not defined: fails are counted and checking continues. done_reason is never 3, and fail_count can exceed 1.

## Test plan
- Load entries {(3,0x0000),(5,0x0002)}, NUM_TEST=2, start. Drive num_inst 0..5 with port 0x0000, then 0x0002 at num_inst 5, then is_halted → pass_count=2, all_pass=1, done_reason=1.
- Same table, port 0x0001 at num_inst 5 → fail_count=1, first_fail_idx=1, first_fail_val=0x0001. With the macro: DONE on that edge, reason 3. Without it: RUN continues until halt, reason 1.
- num_inst jumps 2→9 over entries {3,5,7} → miss_count increments on 3 consecutive cycles, ptr=3.
- No halt, MAX_CYCLES=20 → DONE exactly 20 RUN cycles after entry, cycle_count=19, reason 2.
- reset_n=0 mid-RUN with pass_count=1 → next edge: state=IDLE, all counts 0. Table still holds the loaded entries; a fresh start re-grades them.
- load_en during RUN with a new ans for entry 0 → ignored; the original ans is used for grading.
